// File: rtl/cnt_pair_pkg.sv
// rtl/cnt_pair_pkg.sv - shared types and constants for the counter-pair monitor
package cnt_pair_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int PW_DEF  = 16;
  localparam int EVW_DEF = 8;

  // Largest value representable in w bits; valid for w < 32.
  function automatic logic [31:0] period_sat(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/cnt_pair_monitor_cnt.sv
// rtl/cnt_pair_monitor_cnt.sv - pulse counter with clear, load-one and saturate/wrap select
module pulse_cnt_sat
  import cnt_pair_pkg::*;
#(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_ld1,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX = W'(period_sat(W));

  logic [W-1:0] r_cnt;

  // Priority: clear, then load-one, then increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld1) begin
      r_cnt <= W'(1);
    end else if (i_inc && !(SAT && (r_cnt == MAX))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cnt_pair_monitor.sv
// rtl/cnt_pair_monitor.sv - coincidence interval monitor for the dual counter stage
// Optional carry pulse counters enabled by PAIR_MON_CARRY_EN.
module cnt_pair_monitor
  import cnt_pair_pkg::*;
#(
  parameter int PW  = PW_DEF,
  parameter int EVW = EVW_DEF
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  input  logic           cntA_EQ_cntB,
  input  logic           CoutA,
  input  logic           CoutB,
  output logic [PW-1:0]  period,
  output logic [PW-1:0]  period_min,
  output logic [PW-1:0]  period_max,
  output logic [EVW-1:0] n_events,
  output logic           valid,
  output logic [1:0]     state
`ifdef PAIR_MON_CARRY_EN
  ,
  output logic [EVW-1:0] carriesA,
  output logic [EVW-1:0] carriesB
`endif
);

  state_t        r_state;
  logic [PW-1:0] r_period;
  logic [PW-1:0] r_min;
  logic [PW-1:0] r_max;
  logic          r_valid;
  logic          r_first;
  logic          r_eq_d;
  logic [PW-1:0] w_interval;
  logic          w_event;
  logic          w_take;

  // eq_d resets high so a level already present at reset release is not an event.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_eq_d <= 1'b1;
    else        r_eq_d <= cntA_EQ_cntB;
  end

  assign w_event = cntA_EQ_cntB & ~r_eq_d;
  assign w_take  = en & ~clr & w_event & ((r_state == ARMED) | (r_state == MEASURE));

  pulse_cnt_sat #(.W(PW), .SAT(1'b1)) u_interval (
    .i_clk  (CLK),
    .i_rst_n(rst_n),
    .i_clr  (clr),
    .i_ld1  (w_take),
    .i_inc  (en & (r_state == MEASURE)),
    .o_cnt  (w_interval)
  );

  pulse_cnt_sat #(.W(EVW), .SAT(1'b1)) u_events (
    .i_clk  (CLK),
    .i_rst_n(rst_n),
    .i_clr  (clr),
    .i_ld1  (1'b0),
    .i_inc  (w_take),
    .o_cnt  (n_events)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_period <= '0;
      r_min    <= '1;
      r_max    <= '0;
      r_valid  <= 1'b0;
      r_first  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      if (clr) begin
        r_period <= '0;
        r_min    <= '1;
        r_max    <= '0;
        r_first  <= 1'b1;
        r_state  <= en ? ARMED : IDLE;
      end else if (!en) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE:    r_state <= ARMED;
          ARMED:   if (w_event) r_state <= MEASURE;
          MEASURE: begin
            if (w_event) begin
              r_period <= w_interval;
              r_valid  <= 1'b1;
              r_first  <= 1'b0;
              if (r_first || (w_interval < r_min)) r_min <= w_interval;
              if (r_first || (w_interval > r_max)) r_max <= w_interval;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign period     = r_period;
  assign period_min = r_min;
  assign period_max = r_max;
  assign valid      = r_valid;
  assign state      = r_state;

`ifdef PAIR_MON_CARRY_EN
  pulse_cnt_sat #(.W(EVW), .SAT(1'b0)) u_carry_a (
    .i_clk  (CLK),
    .i_rst_n(rst_n),
    .i_clr  (clr),
    .i_ld1  (1'b0),
    .i_inc  (CoutA & en),
    .o_cnt  (carriesA)
  );

  pulse_cnt_sat #(.W(EVW), .SAT(1'b0)) u_carry_b (
    .i_clk  (CLK),
    .i_rst_n(rst_n),
    .i_clr  (clr),
    .i_ld1  (1'b0),
    .i_inc  (CoutB & en),
    .o_cnt  (carriesB)
  );
`else
  logic w_unused_carry;
  assign w_unused_carry = CoutA ^ CoutB;
`endif

endmodule

// File: tb/tb_cnt_pair_monitor.sv
// tb/tb_cnt_pair_monitor.sv - scoreboard bench for cnt_pair_monitor (PW=16 and PW=4 instances)
module tb_cnt_pair_monitor;

  logic CLK = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, clr = 1'b0, eq = 1'b0, ca = 1'b0, cb = 1'b0;

  logic [15:0] p16, mn16, mx16;
  logic [3:0]  p4, mn4, mx4;
  logic [7:0]  n16, n4;
  logic        v16, v4;
  logic [1:0]  st16, st4;
`ifdef PAIR_MON_CARRY_EN
  logic [7:0]  ca16, cb16, ca4, cb4;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int p; int mn; int mx; int n; int c;
  } exp_t;
  exp_t q16[$];
  exp_t q4[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  cnt_pair_monitor #(.PW(16), .EVW(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .en(en), .clr(clr), .cntA_EQ_cntB(eq),
    .CoutA(ca), .CoutB(cb), .period(p16), .period_min(mn16), .period_max(mx16),
    .n_events(n16), .valid(v16), .state(st16)
`ifdef PAIR_MON_CARRY_EN
    , .carriesA(ca16), .carriesB(cb16)
`endif
  );

  cnt_pair_monitor #(.PW(4), .EVW(8)) dut4 (
    .CLK(CLK), .rst_n(rst_n), .en(en), .clr(clr), .cntA_EQ_cntB(eq),
    .CoutA(ca), .CoutB(cb), .period(p4), .period_min(mn4), .period_max(mx4),
    .n_events(n4), .valid(v4), .state(st4)
`ifdef PAIR_MON_CARRY_EN
    , .carriesA(ca4), .carriesB(cb4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Rising edge of eq exactly gap cycles after the previous one.
  task automatic rise(input int gap);
    eq = 1'b0;
    repeat (gap - 1) tick();
    eq = 1'b1;
    tick();
  endtask

  task automatic expv(input int p, input int mn, input int mx,
                      input int p_4, input int mn_4, input int mx_4, input int n);
    exp_t e;
    e.p = p; e.mn = mn; e.mx = mx; e.n = n; e.c = cyc;
    q16.push_back(e);
    e.p = p_4; e.mn = mn_4; e.mx = mx_4;
    q4.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (v16) begin
      if (q16.size() == 0) chk("valid16_unexpected", 1, 0);
      else begin
        e = q16.pop_front();
        chk("period16", p16, e.p);
        chk("min16", mn16, e.mn);
        chk("max16", mx16, e.mx);
        chk("nev16", n16, e.n);
        chk("lat16", cyc, e.c);
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (v4) begin
      if (q4.size() == 0) chk("valid4_unexpected", 1, 0);
      else begin
        e = q4.pop_front();
        chk("period4", p4, e.p);
        chk("min4", mn4, e.mn);
        chk("max4", mx4, e.mx);
        chk("nev4", n4, e.n);
        chk("lat4", cyc, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the equality level already high.
    eq = 1'b1; en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", st16, 0);
    chk("rst_period", p16, 0);
    chk("rst_min", mn16, 16'hFFFF);
    chk("rst_max", mx16, 0);
    chk("rst_nev", n16, 0);
    chk("rst_valid", v16, 0);
    chk("rst_min4", mn4, 4'hF);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    #1 chk("post_rst_idle", st16, 0);
    tick();
    chk("armed", st16, 1);
    repeat (3) tick();
    chk("held_level_no_event", n16, 0);
    chk("held_level_armed", st16, 1);
    rise(2);
    chk("first_event_measure", st16, 2);
    chk("first_event_nev", n16, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_armed", st16, 1);
    chk("clr_nev", n16, 0);

    // Interval measurement, min/max tracking and PW=4 saturation.
    rise(2);
    rise(7);  expv(7, 7, 7, 7, 7, 7, 2);
    rise(13); expv(13, 7, 13, 13, 7, 13, 3);
    chk("nev_after3", n16, 3);
    rise(5);  expv(5, 5, 13, 5, 5, 13, 4);
    rise(21); expv(21, 5, 21, 15, 5, 15, 5);
    rise(5);  expv(5, 5, 21, 5, 5, 15, 6);

    // clr coincident with an event while measuring.
    eq = 1'b0; tick();
    eq = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    chk("clrev_period", p16, 0);
    chk("clrev_min", mn16, 16'hFFFF);
    chk("clrev_max", mx16, 0);
    chk("clrev_nev", n16, 0);
    chk("clrev_state", st16, 1);
    chk("clrev_min4", mn4, 4'hF);
    rise(2);
    chk("after_clr_measure", st16, 2);
    rise(9);  expv(9, 9, 9, 9, 9, 9, 2);

    // Asynchronous reset between clock edges while measuring.
    eq = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", st16, 0);
    chk("arst_period", p16, 0);
    chk("arst_min", mn16, 16'hFFFF);
    chk("arst_max", mx16, 0);
    chk("arst_nev", n16, 0);
    chk("arst_state4", st4, 0);
    eq = 1'b1;
    @(negedge CLK);
    rst_n = 1'b1;
    tick();
    chk("arst_rel_armed", st16, 1);
    tick();
    chk("arst_rel_nev", n16, 0);
    rise(2);
    chk("arst_rel_event", n16, 1);
    rise(4);  expv(4, 4, 4, 4, 4, 4, 2);

    // en low: back to IDLE, events ignored, results held.
    en = 1'b0; tick();
    chk("en0_idle", st16, 0);
    rise(3);
    chk("en0_nev_hold", n16, 2);
    chk("en0_period_hold", p16, 4);
    en = 1'b1; tick();
    chk("en1_armed", st16, 1);
    rise(2);
    rise(6);  expv(6, 4, 6, 6, 4, 6, 4);

`ifdef PAIR_MON_CARRY_EN
    chk("carry_start", ca16, 0);
    for (int i = 0; i < 300; i++) begin
      ca = 1'b1; cb = (i % 60 == 0); tick();
      ca = 1'b0; cb = 1'b0; tick();
    end
    chk("carriesA_wrap", ca16, 44);
    chk("carriesB", cb16, 5);
    chk("carriesA_4", ca4, 44);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ca = 1'b1; cb = 1'b1; tick();
      ca = 1'b0; cb = 1'b0; tick();
    end
    chk("carriesA_en0", ca16, 44);
    chk("carriesB_en0", cb16, 5);
    en = 1'b1; clr = 1'b1; ca = 1'b1; cb = 1'b1; tick();
    clr = 1'b0; ca = 1'b0; cb = 1'b0;
    chk("carriesA_clr", ca16, 0);
    chk("carriesB_clr", cb16, 0);
`endif

    repeat (3) tick();
    chk("q16_drained", q16.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
